// File: rtl/uart_cmd_loader_pkg.sv
// Shared command-definition constants and state types for the UART command loader.
// CMD_SIZE and the default sync byte are also consumed by the NAND controller.
package uart_cmd_loader_pkg;

    localparam int         CMD_SIZE          = 7;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         RAM_AW            = 12;
    localparam int         IDX_W             = $clog2(CMD_SIZE);

    typedef enum logic [1:0] {HUNT, LOAD, DONE} loader_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Command index zero-extended onto the 12-bit RAM address bus.
    function automatic logic [RAM_AW-1:0] idx_to_addr(input logic [IDX_W-1:0] idx);
        return {{(RAM_AW - IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/uart_cmd_loader_if.sv
// Bundle of the loader's serial input, control handshake and command-RAM write port.
interface uart_cmd_loader_if;
    import uart_cmd_loader_pkg::*;

    logic              rx;
    logic              ready_clr;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;
    logic              ready;
    logic              busy;
    logic              frame_err;
    logic              timeout_err;

    modport master (
        input  rx, ready_clr,
        output ram_addr, ram_data, ram_we, ready, busy, frame_err, timeout_err
    );

    modport slave (
        output rx, ready_clr,
        input  ram_addr, ram_data, ram_we, ready, busy, frame_err, timeout_err
    );

endinterface

// File: rtl/uart_cmd_loader_rx.sv
// 8N1 UART receiver with a 2-FF input synchronizer; emits one-cycle byte_valid
// or frame_err pulses after the stop-bit sample.
module uart_rx
    import uart_cmd_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        sync1_d      = rx;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            // A start bit that is high again at mid-bit was a glitch: drop it silently.
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    byte_valid_d = sync2_q;
                    frame_err_d  = !sync2_q;
                    state_d      = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_cmd_loader.sv
// Loads a SYNC_BYTE-framed command of CMD_SIZE bytes from a UART into command RAM
// and holds ready until the NAND controller releases it with ready_clr.
module uart_cmd_loader
    import uart_cmd_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         TIMEOUT_CLKS = 4096,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    uart_cmd_loader_if.master bus
);

    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_SIZE - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (bus.rx),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_frame_err)
    );

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        idle_d        = idle_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        ram_we_d      = 1'b0;
        frame_err_d   = rx_frame_err;
        timeout_err_d = 1'b0;
        case (state_q)
            HUNT: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    idle_d  = '0;
                end
            end
            // Inside a frame every byte is payload, including one equal to SYNC_BYTE.
            LOAD: begin
                if (rx_frame_err) begin
                    state_d = HUNT;
                    idx_d   = '0;
                    idle_d  = '0;
                end else if (rx_valid) begin
                    ram_addr_d = idx_to_addr(idx_q);
                    ram_data_d = rx_byte;
                    ram_we_d   = 1'b1;
                    idle_d     = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (idle_q == TO_LAST) begin
                    state_d       = HUNT;
                    idx_d         = '0;
                    idle_d        = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.ready_clr) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
        busy_d  = (state_d == LOAD);
        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            idx_q         <= '0;
            idle_q        <= '0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            ram_we_q      <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            idle_q        <= idle_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            ram_we_q      <= ram_we_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Self-checking bench for uart_cmd_loader: serial frames with random payloads are
// compared against a frame-level reference model of expected RAM writes and status.
module tb_uart_cmd_loader;
    import uart_cmd_loader_pkg::*;

    localparam int         CPB  = 16;
    localparam int         TO   = 4096;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_cmd_loader_if bus();

    uart_cmd_loader #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    int  testsRun    = 0;
    int  testsFailed = 0;
    wr_t expQ[$];
    wr_t gotQ[$];
    int  frameErrCnt = 0;
    int  timeoutCnt  = 0;

    // Reference model: 0 = hunting for sync, 1 = collecting payload, 2 = command ready
    int  mMode = 0;
    int  mIdx  = 0;

    function automatic wr_t mkWr(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) gotQ.push_back(mkWr(int'(bus.ram_addr), int'(bus.ram_data)));
        if (bus.frame_err === 1'b1) frameErrCnt++;
        if (bus.timeout_err === 1'b1) timeoutCnt++;
    end

    task automatic modelByte(input logic [7:0] b);
        if (mMode == 0) begin
            if (b == SYNC) begin
                mMode = 1;
                mIdx  = 0;
            end
        end else if (mMode == 1) begin
            expQ.push_back(mkWr(mIdx, int'(b)));
            mIdx++;
            if (mIdx == CMD_SIZE) mMode = 2;
        end
    endtask

    task automatic modelAbort();
        if (mMode == 1) mMode = 0;
        mIdx = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkWrites(input string tag);
        int n;
        checkOutput({tag, "_nwrites"}, gotQ.size(), expQ.size());
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), gotQ[i].addr, expQ[i].addr);
            checkOutput($sformatf("%s_data%0d", tag, i), gotQ[i].data, expQ[i].data);
        end
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_ready"}, bus.ready, (mMode == 2) ? 1 : 0);
        checkOutput({tag, "_busy"},  bus.busy,  (mMode == 1) ? 1 : 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_addr"},    bus.ram_addr,    0);
        checkOutput({tag, "_data"},    bus.ram_data,    0);
        checkOutput({tag, "_we"},      bus.ram_we,      0);
        checkOutput({tag, "_ready"},   bus.ready,       0);
        checkOutput({tag, "_busy"},    bus.busy,        0);
        checkOutput({tag, "_ferr"},    bus.frame_err,   0);
        checkOutput({tag, "_terr"},    bus.timeout_err, 0);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit stopOk);
        @(negedge clk) bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stopOk;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
        repeat (CPB) @(negedge clk);
        if (stopOk) modelByte(b);
        else        modelAbort();
    endtask

    task automatic sendRandomFrame();
        applyStimulus(SYNC, 1'b1);
        for (int i = 0; i < CMD_SIZE; i++) applyStimulus(8'($urandom), 1'b1);
    endtask

    task automatic pulseReadyClr();
        @(negedge clk) bus.ready_clr = 1'b1;
        @(negedge clk) bus.ready_clr = 1'b0;
        if (mMode == 2) mMode = 0;
    endtask

    initial begin
        logic [7:0] s037[8];
        int         cnt0;
        s037 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h02};

        rst = 1'b1;
        bus.rx = 1'b1;
        bus.ready_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Fixed command frame
        foreach (s037[i]) applyStimulus(s037[i], 1'b1);
        checkWrites("fixed_frame");
        checkState("fixed_frame");

        // Bytes arriving while the command is ready are ignored until released
        applyStimulus(SYNC, 1'b1);
        applyStimulus(8'h99, 1'b1);
        checkWrites("done_ignore");
        checkOutput("done_ready_held", bus.ready, 1);
        pulseReadyClr();
        checkOutput("clr_ready_low", bus.ready, 0);
        checkState("after_clr");

        // Junk before sync is skipped
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(SYNC, 1'b1);
        for (int i = 0; i < CMD_SIZE; i++) applyStimulus(8'(8'h11 + i), 1'b1);
        checkWrites("junk_sync");
        checkState("junk_sync");
        pulseReadyClr();

        // Inter-byte timeout aborts the frame, written bytes stay
        applyStimulus(SYNC, 1'b1);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        checkState("pre_timeout");
        cnt0 = timeoutCnt;
        repeat (5000) @(negedge clk);
        modelAbort();
        checkOutput("timeout_pulses", timeoutCnt - cnt0, 1);
        checkWrites("timeout");
        checkState("timeout");
        sendRandomFrame();
        checkWrites("post_timeout");
        checkState("post_timeout");
        pulseReadyClr();

        // Bad stop bit aborts the frame; ready_clr mid-frame has no effect
        cnt0 = frameErrCnt;
        applyStimulus(SYNC, 1'b1);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'($urandom), 1'b0);
        checkOutput("frame_err_pulses", frameErrCnt - cnt0, 1);
        checkWrites("frame_err");
        checkState("frame_err");
        applyStimulus(SYNC, 1'b1);
        applyStimulus(8'($urandom), 1'b1);
        pulseReadyClr();
        for (int i = 1; i < CMD_SIZE; i++) applyStimulus(8'($urandom), 1'b1);
        checkWrites("post_frame_err");
        checkState("post_frame_err");
        pulseReadyClr();

        // Reset in the middle of the fourth payload byte
        applyStimulus(SYNC, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 1'b1);
        @(negedge clk) bus.rx = 1'b0;
        repeat (CPB + 3 * CPB) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("mid_reset");
        mMode = 0;
        mIdx  = 0;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        checkWrites("mid_reset");
        checkState("mid_reset");

        // Short low glitch inside a frame must not produce a byte
        cnt0 = frameErrCnt;
        applyStimulus(SYNC, 1'b1);
        @(negedge clk) bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        for (int i = 0; i < CMD_SIZE; i++) applyStimulus(8'($urandom), 1'b1);
        checkOutput("glitch_no_ferr", frameErrCnt - cnt0, 0);
        checkWrites("glitch");
        checkState("glitch");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
